reg_bank_sequencer: RTL
=======================

Name: reg_bank_sequencer

Overview:
- Initiator side of the register-bank access interface. Accepts register-level commands (READ, WRITE, MOVE, XCHG) over a valid/ready handshake.
- Sequences them into single-cycle read/write phases on the bank's select lines and bidirectional 16-bit data bus.
- Returns a result over a second valid/ready handshake.
- Sits between the instruction execute unit and Banco_de_Registros.

Parameters:
- DATA_W, 16, bank data-bus width (fixed at 16; parameterised only for the package constants)
- REG_SEL_W, 3, register-select width

Ports:
- clk  input  1  system clock, all logic on rising edge
- reset  input  1  synchronous, active-high reset
- req_valid  input  1  command present
- req_ready  output  1  sequencer can accept a command
- req_op  input  2  00 READ, 01 WRITE, 10 MOVE, 11 XCHG
- req_size  input  1  0 = 8-bit, 1 = 16-bit
- req_src  input  3  source/target operand
- req_dst  input  3  destination operand (MOVE, XCHG)
- req_imm  input  16  write data (WRITE only)
- rsp_valid  output  1  result present
- rsp_ready  input  1  consumer takes result
- rsp_data  output  16  result; 8-bit results are zero-extended
- select_reg  output  3  bank register select
- size  output  1  bank access size
- select_high_low  output  1  bank byte select
- select_data_h_reg  output  1  bank high-byte data source
- read_write  output  1  0 = read (bank drives data), 1 = write (sequencer drives data)
- data  inout  16  bank data bus

Behaviour:
Operand mapping:
- 16-bit: select_reg = operand, select_high_low = 0.
- 8-bit: select_reg = {1'b0, operand[1:0]}, select_high_low = operand[2] (0-3 low bytes, 4-7 high bytes).
- select_data_h_reg is always 0: the write byte travels on data[7:0].

Bus timing:
- Read phase: read_write = 0, data released (high-Z). Bank drives combinationally. Sequencer samples data at the closing rising edge. 8-bit reads use data[7:0].
- Write phase: read_write = 1, sequencer drives data. 8-bit writes place the byte on data[7:0] with data[15:8] = 0. Bank latches at the closing rising edge.
- data is driven only during write phases and never in the same cycle read_write = 0.

Outputs:
- Bank outputs are decoded from the state register and latched command registers only.
- No combinational path from req_* to bank ports.

States: IDLE, RD_A, RD_B, WR_B, WR_A, RESP.
- IDLE: req_ready = 1. On req_valid & req_ready, latch op/size/src/dst/imm.
  - READ -> RD_A
  - WRITE -> WR_A (write data = imm)
  - MOVE -> RD_A
  - XCHG -> RD_A
- RD_A: read src into tmp_a.
  - READ -> RESP
  - MOVE -> WR_B
  - XCHG -> RD_B
- RD_B: read dst into tmp_b -> WR_B.
- WR_B: write tmp_a to dst.
  - MOVE -> RESP
  - XCHG -> WR_A
- WR_A: write to src (imm for WRITE, tmp_b for XCHG) -> RESP.
- RESP: rsp_valid = 1. Hold rsp_data stable until rsp_ready, then -> IDLE.
  - rsp_data values: READ = tmp_a; WRITE = imm; MOVE = tmp_a; XCHG = tmp_a (old src).

Latency:
- Measured from the acceptance edge to the first cycle rsp_valid = 1: READ 2, WRITE 2, MOVE 3, XCHG 5.
- Back-to-back throughput: one extra IDLE cycle per command.

Boundary conditions:
- req_ready = 0 in every state except IDLE. req_* is ignored outside IDLE.
- rsp_ready is allowed high before rsp_valid. With rsp_ready held high, RESP lasts exactly one cycle.
- MOVE/XCHG with src == dst: full sequence still runs; register value ends unchanged.
- Register values in 8-bit ops are masked to [7:0] before write.

Reset (synchronous, takes priority over all transitions):
- State -> IDLE, req_ready = 1, rsp_valid = 0, rsp_data = 0.
- read_write = 0, data high-Z, select_reg = 0, size = 1, select_high_low = 0, select_data_h_reg = 0, tmp_a = tmp_b = 0.
- Reset mid-command abandons it with no further bus phase. Writes completed before the reset edge stand; XCHG can be left half-done.

Decomposition:
- Package reg_bank_pkg holds:
  - Enums: operacion {leer, escribir}, tamano {_8bits, _16bits}, parte_alta_baja, datos_registro_h.
  - Opcode enum: READ, WRITE, MOVE, XCHG.
  - State enum.
  - Function mapping operand+size to {select_reg, select_high_low}.
- The same package is shared with Banco_de_Registros and its benches.
- Single module, no sub-module: tri-state is one continuous assign gated on the write phase.

Test Plan:
- Reset, then WRITE 16-bit src=3 imm=16'hBEEF, then READ 16-bit src=3 -> both responses 2 cycles after accept; rsp_data = BEEF.
- WRITE 16-bit reg0 = 16'h1234, then 8-bit WRITE src=4 (AH) imm=16'h00AB, then READ 16-bit reg0 -> rsp_data = AB34. 8-bit READ src=0 -> rsp_data = 0034.
- Reg1 = 16'h1111, reg2 = 16'h2222; XCHG 16-bit src=1 dst=2 -> rsp after 5 cycles, rsp_data = 1111; READ reg1 = 2222, READ reg2 = 1111.
- MOVE 8-bit src=0 (AL = 34) dst=7 (BH) with rsp_ready low for 3 cycles -> rsp_valid held, req_ready = 0 throughout; BH = 34, BL unchanged.
- Reset asserted during RD_B of an XCHG -> next cycle IDLE, req_ready = 1, rsp_valid = 0, data high-Z; no write phase observed.
- Bus checker, all scenarios: data never driven by the sequencer while read_write = 0.

Source files
------------

// File: rtl/reg_bank_pkg.sv
// Shared types and helpers for the register bank and its initiator (reg_bank_sequencer).
// Holds bank control enums, command opcodes, sequencer states and operand-to-select mapping.
// Also used by Banco_de_Registros and its benches, so value encodings here are part of the bank contract.
package reg_bank_pkg;

  localparam int DATA_W    = 16;
  localparam int REG_SEL_W = 3;

  // Bank control encodings
  typedef enum logic { leer = 1'b0, escribir = 1'b1 } operacion;
  typedef enum logic { _8bits = 1'b0, _16bits = 1'b1 } tamano;
  typedef enum logic { parte_baja = 1'b0, parte_alta = 1'b1 } parte_alta_baja;
  typedef enum logic { datos_bajos = 1'b0, datos_altos = 1'b1 } datos_registro_h;

  // Register-level command opcodes
  typedef enum logic [1:0] {
    READ  = 2'b00,
    WRITE = 2'b01,
    MOVE  = 2'b10,
    XCHG  = 2'b11
  } opcode_t;

  // Sequencer states
  typedef enum logic [2:0] {
    IDLE = 3'd0,
    RD_A = 3'd1,
    RD_B = 3'd2,
    WR_B = 3'd3,
    WR_A = 3'd4,
    RESP = 3'd5
  } state_t;

  typedef struct packed {
    logic [REG_SEL_W-1:0] select_reg;
    logic                 select_high_low;
  } bank_sel_t;

  // 16-bit operands address a whole register. 8-bit operands 0-3 are the low
  // bytes and 4-7 the high bytes of registers 0-3.
  function automatic bank_sel_t map_operand(input logic [REG_SEL_W-1:0] operand,
                                            input tamano                sz);
    bank_sel_t s;
    if (sz == _16bits) begin
      s.select_reg      = operand;
      s.select_high_low = 1'b0;
    end else begin
      s.select_reg      = {1'b0, operand[1:0]};
      s.select_high_low = operand[2];
    end
    return s;
  endfunction

  // Byte operations carry only bits [7:0]; everything else is forced to zero.
  function automatic logic [DATA_W-1:0] size_mask(input logic [DATA_W-1:0] v,
                                                  input tamano             sz);
    return (sz == _16bits) ? v : {{(DATA_W-8){1'b0}}, v[7:0]};
  endfunction

endpackage

// File: rtl/reg_bank_sequencer_if.sv
// Command, response and bank-select signal group of the register-bank sequencer.
// master: the sequencer (accepts commands, returns results, drives bank selects).
// slave: execute unit plus bank side. The bidirectional data bus stays a plain port.
interface reg_bank_sequencer_if;
  import reg_bank_pkg::*;

  // command handshake
  logic                 req_valid;
  logic                 req_ready;
  logic [1:0]           req_op;
  logic                 req_size;
  logic [REG_SEL_W-1:0] req_src;
  logic [REG_SEL_W-1:0] req_dst;
  logic [DATA_W-1:0]    req_imm;

  // result handshake
  logic                 rsp_valid;
  logic                 rsp_ready;
  logic [DATA_W-1:0]    rsp_data;

  // bank control
  logic [REG_SEL_W-1:0] select_reg;
  logic                 size;
  logic                 select_high_low;
  logic                 select_data_h_reg;
  logic                 read_write;

  modport master (
    input  req_valid, req_op, req_size, req_src, req_dst, req_imm, rsp_ready,
    output req_ready, rsp_valid, rsp_data,
    output select_reg, size, select_high_low, select_data_h_reg, read_write
  );

  modport slave (
    output req_valid, req_op, req_size, req_src, req_dst, req_imm, rsp_ready,
    input  req_ready, rsp_valid, rsp_data,
    input  select_reg, size, select_high_low, select_data_h_reg, read_write
  );

endinterface

// File: rtl/reg_bank_sequencer.sv
// Initiator of the register bank: turns READ/WRITE/MOVE/XCHG into single-cycle bank read/write phases.
// Latency accept->rsp_valid: READ 2, WRITE 2, MOVE 3, XCHG 5 cycles; one IDLE cycle between commands.
// req_ready only in IDLE; RESP holds rsp_data until rsp_ready (may be high early, then RESP lasts 1 cycle).
// Ports: clk, reset (sync, active high); bus (master modport: req_*, rsp_*, bank selects, read_write);
//        data (16-bit bidirectional bank bus, driven here only during write phases).
module reg_bank_sequencer #(
  parameter int DATA_W    = 16,
  parameter int REG_SEL_W = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  reg_bank_sequencer_if.master  bus,
  inout  wire  [DATA_W-1:0]     data
);
  import reg_bank_pkg::*;

  state_t               state_q, state_d;
  opcode_t              op_q;
  tamano                size_q;
  logic [REG_SEL_W-1:0] src_q, dst_q;
  logic [DATA_W-1:0]    imm_q;
  logic [DATA_W-1:0]    tmp_a_q, tmp_b_q;

  logic                 accept;
  bank_sel_t            sel;
  tamano                bank_size;
  logic                 wr_phase;
  logic [DATA_W-1:0]    wr_dat;
  logic [DATA_W-1:0]    rsp_dat;

  assign accept = (state_q == IDLE) && bus.req_valid;

  // ---------------------------------------------------------------------------
  // State and datapath registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      op_q    <= READ;
      size_q  <= _16bits;
      src_q   <= '0;
      dst_q   <= '0;
      imm_q   <= '0;
      tmp_a_q <= '0;
      tmp_b_q <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        op_q   <= opcode_t'(bus.req_op);
        size_q <= tamano'(bus.req_size);
        src_q  <= bus.req_src;
        dst_q  <= bus.req_dst;
        // Masked at capture so the write phase and the WRITE result agree.
        imm_q  <= size_mask(bus.req_imm, tamano'(bus.req_size));
      end
      // The bank drives data combinationally during a read phase; sample at
      // the closing edge. Byte reads arrive on data[7:0].
      if (state_q == RD_A) tmp_a_q <= size_mask(data, size_q);
      if (state_q == RD_B) tmp_b_q <= size_mask(data, size_q);
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (bus.req_valid) begin
          unique case (opcode_t'(bus.req_op))
            WRITE:             state_d = WR_A;
            READ, MOVE, XCHG:  state_d = RD_A;
          endcase
        end
      end
      RD_A: begin
        unique case (op_q)
          MOVE:    state_d = WR_B;
          XCHG:    state_d = RD_B;
          default: state_d = RESP;   // READ (WRITE never passes through RD_A)
        endcase
      end
      RD_B:    state_d = WR_B;
      WR_B:    state_d = (op_q == XCHG) ? WR_A : RESP;
      WR_A:    state_d = RESP;
      RESP:    if (bus.rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Output decode: from state and latched command only, so nothing on req_*
  // reaches the bank ports combinationally. Idle values match reset values.
  // ---------------------------------------------------------------------------
  always_comb begin
    sel       = '0;
    bank_size = _16bits;
    wr_phase  = 1'b0;
    wr_dat    = '0;
    rsp_dat   = '0;
    unique case (state_q)
      RD_A: begin
        sel       = map_operand(src_q, size_q);
        bank_size = size_q;
      end
      RD_B: begin
        sel       = map_operand(dst_q, size_q);
        bank_size = size_q;
      end
      WR_B: begin
        sel       = map_operand(dst_q, size_q);
        bank_size = size_q;
        wr_phase  = 1'b1;
        wr_dat    = tmp_a_q;
      end
      WR_A: begin
        sel       = map_operand(src_q, size_q);
        bank_size = size_q;
        wr_phase  = 1'b1;
        wr_dat    = (op_q == WRITE) ? imm_q : tmp_b_q;
      end
      RESP: begin
        // XCHG reports the old source value, which is tmp_a.
        rsp_dat = (op_q == WRITE) ? imm_q : tmp_a_q;
      end
      default: ;
    endcase
  end

  assign bus.req_ready         = (state_q == IDLE);
  assign bus.rsp_valid         = (state_q == RESP);
  assign bus.rsp_data          = rsp_dat;
  assign bus.select_reg        = sel.select_reg;
  assign bus.select_high_low   = sel.select_high_low;
  assign bus.size              = bank_size;
  // The write byte always travels on data[7:0].
  assign bus.select_data_h_reg = datos_bajos;
  assign bus.read_write        = wr_phase ? escribir : leer;

  // Single tri-state driver, gated by the same signal as read_write so the
  // bus is released in every read-phase cycle.
  assign data = wr_phase ? wr_dat : {DATA_W{1'bz}};

endmodule
